lcd_bus_responder: RTL and testbench
====================================

Name: lcd_bus_responder

Overview:
- Synthesizable HD44780-style display-side responder: the far end of the character-LCD bus that the processor's LCD driver writes to.
- Decodes bus cycles (E/RS/RW/DB), executes the command subset below, and holds a 32-character DDRAM (2 lines x 16).
- Reports busy/address on bus reads.
- Exposes a debug read port so the processor bench can check displayed text without a waveform viewer.

Parameters:
- BUSY_CYCLES, 4, clk cycles busy after any accepted write other than clear/reset (must be >= 1).
- CLEAR_CYCLES, 40, clk cycles busy after clear or reset (must be >= 32).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high.
- lcd_e  input  1  enable strobe from the driver.
- lcd_rs  input  1  0 = instruction, 1 = data.
- lcd_rw  input  1  0 = write, 1 = read.
- lcd_db_in  input  8  bus data from the driver.
- lcd_db_out  output  8  read data: {busy, ac[6:0]}.
- lcd_db_oe  output  1  high while this block drives the bus.
- rd_addr  input  5  debug DDRAM index: 0-15 = line 0, 16-31 = line 1.
- rd_char  output  8  DDRAM[rd_addr]; combinational read.
- cursor  output  5  current DDRAM index.
- busy  output  1  busy flag.
- disp_on  output  1  display-control D bit.
- overrun  output  1  sticky; set when a write arrives while busy.
- cmd_strobe  output  1  one-cycle pulse when a byte is accepted.
- cmd_byte  output  8  last accepted byte; valid with cmd_strobe.

Behaviour:
- Edge detection: e_q registers lcd_e each cycle. A write strobe occurs when e_q=1 and lcd_e=0 (falling edge). On that cycle, lcd_rs, lcd_rw and lcd_db_in are sampled.
- Read cycles (lcd_rw=1, lcd_rs=0): while lcd_e=1, lcd_db_oe=1 and lcd_db_out={busy, ac}.
  - ac = line ? 7'h40+col : 7'h00+col.
  - Reads never change state.
  - lcd_rw=1 with lcd_rs=1: oe=1, db_out=DDRAM[cursor], cursor unchanged.
  - Otherwise lcd_db_oe=0 and lcd_db_out=0.
- Byte assembly:
  - 8-bit mode: each write strobe delivers one byte.
  - 4-bit mode (see Optional Feature): high nibble first from lcd_db_in[7:4], then low nibble. The byte is complete on the second strobe.
- Busy rule: a completed byte arriving while busy=1 is discarded, overrun<=1, and no cmd_strobe is issued. A nibble arriving while busy is discarded and the nibble phase resets to high.
- States:
  - IDLE: busy=0.
  - BUSY: down-counter loaded with BUSY_CYCLES; returns to IDLE at 0.
  - CLEAR: writes 0x20 to one DDRAM cell per cycle, index 0..31, while the counter runs from CLEAR_CYCLES. Returns to IDLE when the counter reaches 0, at which point all 32 cells are filled.
  - Every accepted byte moves IDLE->BUSY, or IDLE->CLEAR for 0x01.
- Commands (rs=0), decoded by highest set bit:
  - 0x01 clear: cursor<=0, increment mode<=1, enter CLEAR.
  - 0x02/0x03 home: cursor<=0.
  - 0x04-0x07 entry mode: bit1 = I/D (1 increment, 0 decrement). Bit0 is ignored.
  - 0x08-0x0F display control: disp_on<=bit2. Bits 1:0 are ignored.
  - 0x10-0x1F shift: ignored; still busy.
  - 0x20-0x3F function set: bit4 = DL (1 = 8-bit).
  - 0x40-0x7F CGRAM: ignored; still busy.
  - 0x80-0xFF set DDRAM address:
    - line = bit6, col = bits3:0, cursor = {line, col}.
    - Addresses with bits5:4 != 0 are ignored (cursor unchanged), but still busy.
- Data write (rs=1): DDRAM[cursor]<=byte, then cursor += 1 or -= 1 modulo 32. Wrap is 31->0 and 0->31, crossing lines.
- cmd_strobe is asserted in the same cycle the byte is accepted, for both data and commands. cmd_byte holds its value until the next accepted byte.
- Reset:
  - Values: cursor=0, ac=0, disp_on=0, overrun=0, increment mode, 8-bit mode, nibble phase high, e_q=0, cmd_strobe=0, cmd_byte=0, lcd_db_oe=0.
  - Then enters CLEAR (busy=1 for CLEAR_CYCLES).
  - Reset asserted mid-operation (mid-clear, mid-nibble, mid-busy) aborts the operation and restarts this sequence.
- Simultaneous events: reset has priority over a strobe. An edge on the same cycle busy falls to 0 is still rejected (busy is evaluated before the update).

Optional Feature:
- Macro: LCD_BUS_RESPONDER_NIBBLE_EN.
- Defined: function set DL=0 selects 4-bit mode with nibble assembly as above. DL=1 returns to 8-bit mode and resets the nibble phase.
- Undefined: DL is ignored, the block is always in 8-bit mode, and no nibble logic is synthesized.

Test Plan:
- Reset for 1 cycle, release, wait CLEAR_CYCLES+1:
  - busy is 1 throughout CLEAR, then 0.
  - rd_char=0x20 for all 32 indices.
  - cursor=0.
- Write data 0x48, 0x49 after reset clears -> rd_char[0]=0x48, rd_char[1]=0x49, cursor=2. Each write gives one cmd_strobe.
- Write 0xC5, then data 0x41 -> cursor=21 before the data write, rd_char[21]=0x41, cursor=22.
- Write 0x80, then entry mode 0x04, then data 0x5A -> DDRAM[0]=0x5A, cursor=31. Data 0x5B -> DDRAM[31]=0x5B, cursor=30.
- Issue a second write 1 cycle after the first -> second byte dropped, overrun=1, no second cmd_strobe. A read with rw=1, rs=0 gives lcd_db_out[7]=1.
- (NIBBLE_EN) Send 0x28 as one 8-bit write, then data 0x4 and 0x1 as two nibble writes -> DDRAM[cursor]=0x41. Reset between the two nibbles -> phase returns to high and no write occurs.

Source files
------------

// File: rtl/lcd_bus_responder.sv
// HD44780-style display-side bus responder: decodes E/RS/RW/DB cycles, executes a command subset, holds a 2x16 DDRAM.
// Optional 4-bit (nibble) bus mode is compiled in when LCD_BUS_RESPONDER_NIBBLE_EN is defined.
module lcd_bus_responder #(
  parameter int BUSY_CYCLES  = 4,
  parameter int CLEAR_CYCLES = 40
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lcd_e,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] lcd_db_in,
  output logic [7:0] lcd_db_out,
  output logic       lcd_db_oe,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_char,
  output logic [4:0] cursor,
  output logic       busy,
  output logic       disp_on,
  output logic       overrun,
  output logic       cmd_strobe,
  output logic [7:0] cmd_byte
);

  localparam int MAXC = (BUSY_CYCLES > CLEAR_CYCLES) ? BUSY_CYCLES : CLEAR_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {IDLE, BUSY, CLEAR} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [5:0]    clr_idx;
  logic          e_q;
  logic          incr;
  logic [7:0]    ddram [0:31];

  logic       wr_strobe;
  logic       byte_done;
  logic [7:0] byte_val;
  logic       accept;
  logic       ram_we;
  logic [4:0] ram_addr;
  logic [7:0] ram_data;

  assign wr_strobe = e_q & ~lcd_e & ~lcd_rw;
  assign busy      = (state != IDLE);
  assign accept    = byte_done & (state == IDLE);

`ifdef LCD_BUS_RESPONDER_NIBBLE_EN
  logic       eight_bit;
  logic       phase_low;
  logic [3:0] hi_nib;

  always_comb begin
    byte_done = wr_strobe;
    byte_val  = lcd_db_in;
    if (!eight_bit) begin
      byte_done = wr_strobe & phase_low;
      byte_val  = {hi_nib, lcd_db_in[7:4]};
    end
  end

  // Any nibble seen while busy (first or second) drops the phase back to high.
  always_ff @(posedge clk) begin
    if (reset) begin
      eight_bit <= 1'b1;
      phase_low <= 1'b0;
      hi_nib    <= 4'h0;
    end else begin
      if (wr_strobe && !eight_bit) begin
        if (busy || phase_low) begin
          phase_low <= 1'b0;
        end else begin
          hi_nib    <= lcd_db_in[7:4];
          phase_low <= 1'b1;
        end
      end
      if (accept && !lcd_rs && byte_val[7:5] == 3'b001) begin
        eight_bit <= byte_val[4];
        phase_low <= 1'b0;
      end
    end
  end
`else
  assign byte_done = wr_strobe;
  assign byte_val  = lcd_db_in;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q        <= 1'b0;
      state      <= CLEAR;
      cnt        <= CW'(CLEAR_CYCLES);
      clr_idx    <= 6'd0;
      cursor     <= 5'd0;
      incr       <= 1'b1;
      disp_on    <= 1'b0;
      overrun    <= 1'b0;
      cmd_strobe <= 1'b0;
      cmd_byte   <= 8'h00;
    end else begin
      e_q        <= lcd_e;
      cmd_strobe <= 1'b0;
      if (state != IDLE) begin
        cnt <= cnt - CW'(1);
        if (cnt <= CW'(1)) state <= IDLE;
        if (state == CLEAR && !clr_idx[5]) clr_idx <= clr_idx + 6'd1;
      end
      if (byte_done && state != IDLE) overrun <= 1'b1;
      if (accept) begin
        cmd_strobe <= 1'b1;
        cmd_byte   <= byte_val;
        state      <= BUSY;
        cnt        <= CW'(BUSY_CYCLES);
        if (lcd_rs) begin
          cursor <= incr ? cursor + 5'd1 : cursor - 5'd1;
        end else begin
          casez (byte_val)
            8'b1???????: if (byte_val[5:4] == 2'b00) cursor <= {byte_val[6], byte_val[3:0]};
            8'b00001???: disp_on <= byte_val[2];
            8'b000001??: incr <= byte_val[1];
            8'b0000001?: cursor <= 5'd0;
            8'b00000001: begin
              cursor  <= 5'd0;
              incr    <= 1'b1;
              state   <= CLEAR;
              cnt     <= CW'(CLEAR_CYCLES);
              clr_idx <= 6'd0;
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Clear fill and data writes never coincide: data is only accepted while idle.
  always_comb begin
    ram_we   = !reset && ((state == CLEAR && !clr_idx[5]) || (accept && lcd_rs));
    ram_addr = cursor;
    ram_data = byte_val;
    if (state == CLEAR) begin
      ram_addr = clr_idx[4:0];
      ram_data = 8'h20;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) ddram[ram_addr] <= ram_data;
  end

  assign rd_char = ddram[rd_addr];

  always_comb begin
    lcd_db_oe  = lcd_e & lcd_rw & ~reset;
    lcd_db_out = 8'h00;
    if (lcd_db_oe) begin
      if (lcd_rs) lcd_db_out = ddram[cursor];
      else        lcd_db_out = {busy, cursor[4], 2'b00, cursor[3:0]};
    end
  end

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Self-checking bench for lcd_bus_responder: vector table plus hand sequences, cmd_byte scoreboard.
module tb_lcd_bus_responder;
  localparam int BC = 4;
  localparam int CC = 40;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       lcd_e = 1'b0, lcd_rs = 1'b0, lcd_rw = 1'b0;
  logic [7:0] lcd_db_in = 8'h00;
  logic [4:0] rd_addr = 5'd0;
  logic [7:0] lcd_db_out, rd_char, cmd_byte;
  logic       lcd_db_oe, busy, disp_on, overrun, cmd_strobe;
  logic [4:0] cursor;

  lcd_bus_responder #(.BUSY_CYCLES(BC), .CLEAR_CYCLES(CC)) dut (
    .clk(clk), .reset(reset), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_db_in(lcd_db_in), .lcd_db_out(lcd_db_out), .lcd_db_oe(lcd_db_oe),
    .rd_addr(rd_addr), .rd_char(rd_char), .cursor(cursor), .busy(busy),
    .disp_on(disp_on), .overrun(overrun), .cmd_strobe(cmd_strobe), .cmd_byte(cmd_byte)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] sb_q[$];

  typedef struct {
    logic       rs;
    logic [7:0] data;
    logic [4:0] addr;
    logic [7:0] exp_char;
    logic [4:0] exp_cursor;
    logic       exp_disp;
    int         exp_busy;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  always @(negedge clk) begin
    if (cmd_strobe === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL cmd_unexpected: got strobe with byte 0x%0h, required no strobe", cmd_byte);
      end else begin
        check("cmd_byte", {24'h0, cmd_byte}, {24'h0, sb_q.pop_front()});
      end
    end
  end

  task automatic bus_write(input logic rs, input logic [7:0] d);
    @(negedge clk);
    lcd_rw = 1'b0; lcd_rs = rs; lcd_db_in = d; lcd_e = 1'b1;
    @(negedge clk);
    lcd_e = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy !== 1'b0 && n < CC + 20) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic bus_read_check(input string name, input logic rs, input logic [7:0] exp);
    @(negedge clk);
    lcd_rw = 1'b1; lcd_rs = rs; lcd_e = 1'b1;
    #1;
    check({name, "_oe"}, {31'h0, lcd_db_oe}, 32'd1);
    check({name, "_db"}, {24'h0, lcd_db_out}, {24'h0, exp});
    @(negedge clk);
    lcd_e = 1'b0;
    #1;
    check({name, "_oe_off"}, {31'h0, lcd_db_oe}, 32'd0);
    @(negedge clk);
    lcd_rw = 1'b0;
  endtask

  task automatic check_cell(input string name, input logic [4:0] a, input logic [7:0] exp);
    rd_addr = a;
    #1;
    check(name, {24'h0, rd_char}, {24'h0, exp});
  endtask

  task automatic do_reset();
    int n;
    @(negedge clk);
    reset = 1'b1; lcd_e = 1'b0; lcd_rw = 1'b0;
    @(negedge clk);
    check("rst_cursor", {27'h0, cursor}, 32'd0);
    check("rst_disp_on", {31'h0, disp_on}, 32'd0);
    check("rst_overrun", {31'h0, overrun}, 32'd0);
    check("rst_cmd_strobe", {31'h0, cmd_strobe}, 32'd0);
    check("rst_cmd_byte", {24'h0, cmd_byte}, 32'd0);
    check("rst_oe", {31'h0, lcd_db_oe}, 32'd0);
    check("rst_busy", {31'h0, busy}, 32'd1);
    reset = 1'b0;
    wait_idle(n);
    check("clear_busy_cycles", n, CC);
    check("post_clear_cursor", {27'h0, cursor}, 32'd0);
    for (int i = 0; i < 32; i++) check_cell("clear_fill", 5'(i), 8'h20);
  endtask

  vec_t vecs[23];

  initial begin
    int n;
    //         rs    data   addr   char   cursor disp busy
    vecs[0]  = '{1'b1, 8'h48, 5'd0,  8'h48, 5'd1,  1'b0, BC};
    vecs[1]  = '{1'b1, 8'h49, 5'd1,  8'h49, 5'd2,  1'b0, BC};
    vecs[2]  = '{1'b0, 8'hC5, 5'd21, 8'h20, 5'd21, 1'b0, BC};
    vecs[3]  = '{1'b1, 8'h41, 5'd21, 8'h41, 5'd22, 1'b0, BC};
    vecs[4]  = '{1'b0, 8'h80, 5'd0,  8'h48, 5'd0,  1'b0, BC};
    vecs[5]  = '{1'b0, 8'h04, 5'd0,  8'h48, 5'd0,  1'b0, BC};
    vecs[6]  = '{1'b1, 8'h5A, 5'd0,  8'h5A, 5'd31, 1'b0, BC};
    vecs[7]  = '{1'b1, 8'h5B, 5'd31, 8'h5B, 5'd30, 1'b0, BC};
    vecs[8]  = '{1'b0, 8'h06, 5'd30, 8'h20, 5'd30, 1'b0, BC};
    vecs[9]  = '{1'b1, 8'h31, 5'd30, 8'h31, 5'd31, 1'b0, BC};
    vecs[10] = '{1'b1, 8'h32, 5'd31, 8'h32, 5'd0,  1'b0, BC};
    vecs[11] = '{1'b0, 8'h0C, 5'd0,  8'h5A, 5'd0,  1'b1, BC};
    vecs[12] = '{1'b0, 8'hB3, 5'd0,  8'h5A, 5'd0,  1'b1, BC};
    vecs[13] = '{1'b0, 8'h8F, 5'd15, 8'h20, 5'd15, 1'b1, BC};
    vecs[14] = '{1'b0, 8'h18, 5'd15, 8'h20, 5'd15, 1'b1, BC};
    vecs[15] = '{1'b0, 8'h40, 5'd15, 8'h20, 5'd15, 1'b1, BC};
    vecs[16] = '{1'b0, 8'h02, 5'd0,  8'h5A, 5'd0,  1'b1, BC};
    vecs[17] = '{1'b0, 8'hCF, 5'd31, 8'h32, 5'd31, 1'b1, BC};
    vecs[18] = '{1'b0, 8'h0B, 5'd31, 8'h32, 5'd31, 1'b0, BC};
    vecs[19] = '{1'b0, 8'h04, 5'd31, 8'h32, 5'd31, 1'b0, BC};
    vecs[20] = '{1'b0, 8'h01, 5'd21, 8'h20, 5'd0,  1'b0, CC};
    vecs[21] = '{1'b1, 8'h55, 5'd0,  8'h55, 5'd1,  1'b0, BC};
    vecs[22] = '{1'b0, 8'hC0, 5'd31, 8'h20, 5'd16, 1'b0, BC};

    repeat (3) @(negedge clk);
    do_reset();

    foreach (vecs[i]) begin
      sb_q.push_back(vecs[i].data);
      bus_write(vecs[i].rs, vecs[i].data);
      wait_idle(n);
      check($sformatf("v%0d_busy_cycles", i), n, vecs[i].exp_busy);
      check($sformatf("v%0d_cursor", i), {27'h0, cursor}, {27'h0, vecs[i].exp_cursor});
      check($sformatf("v%0d_disp_on", i), {31'h0, disp_on}, {31'h0, vecs[i].exp_disp});
      check_cell($sformatf("v%0d_char", i), vecs[i].addr, vecs[i].exp_char);
    end

    // Idle reads: status shows line 1 col 0, data read returns cell under cursor.
    bus_read_check("rd_status_idle", 1'b0, 8'h40);
    bus_read_check("rd_data_idle", 1'b1, 8'h20);
    check("rd_no_move", {27'h0, cursor}, 32'd16);

    // Back-to-back writes: the second lands while busy and must be dropped.
    sb_q.push_back(8'h61);
    @(negedge clk);
    lcd_rw = 1'b0; lcd_rs = 1'b1; lcd_db_in = 8'h61; lcd_e = 1'b1;
    @(negedge clk);
    lcd_e = 1'b0;
    @(negedge clk);
    lcd_db_in = 8'h62; lcd_e = 1'b1;
    @(negedge clk);
    lcd_e = 1'b0;
    bus_read_check("rd_status_busy", 1'b0, 8'hC1);
    wait_idle(n);
    check("ovr_flag", {31'h0, overrun}, 32'd1);
    check("ovr_cursor", {27'h0, cursor}, 32'd17);
    check_cell("ovr_first_kept", 5'd16, 8'h61);
    check_cell("ovr_second_dropped", 5'd17, 8'h20);

    // Reset in the middle of a busy period restarts the clear sequence.
    sb_q.push_back(8'h77);
    bus_write(1'b1, 8'h77);
    do_reset();

`ifdef LCD_BUS_RESPONDER_NIBBLE_EN
    sb_q.push_back(8'h28);
    bus_write(1'b0, 8'h28);
    wait_idle(n);
    bus_write(1'b1, 8'h40);
    check("nib_hi_not_busy", {31'h0, busy}, 32'd0);
    sb_q.push_back(8'h41);
    bus_write(1'b1, 8'h10);
    wait_idle(n);
    check("nib_busy_cycles", n, BC);
    check_cell("nib_char", 5'd0, 8'h41);
    check("nib_cursor", {27'h0, cursor}, 32'd1);
    bus_write(1'b1, 8'h50);
    do_reset();
    sb_q.push_back(8'h33);
    bus_write(1'b1, 8'h33);
    wait_idle(n);
    check_cell("nib_rst_char", 5'd0, 8'h33);
    check("nib_rst_cursor", {27'h0, cursor}, 32'd1);
`else
    sb_q.push_back(8'h20);
    bus_write(1'b0, 8'h20);
    wait_idle(n);
    sb_q.push_back(8'h41);
    bus_write(1'b1, 8'h41);
    wait_idle(n);
    check_cell("dl_ignored_char", 5'd0, 8'h41);
    check("dl_ignored_cursor", {27'h0, cursor}, 32'd1);
`endif

    repeat (3) @(negedge clk);
    check("sb_empty", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish before 200000");
    $fatal(1);
  end
endmodule
